lsu_ctrl: RTL
=============

LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 255, SHALL set the maximum number of REQ-state cycles without mem_ack before abort.
REQ-002 clk  in  1  sole clock, rising-edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 cpu_valid  in  1  request strobe.
REQ-005 cpu_we  in  1  1=store, 0=load.
REQ-006 cpu_op  in  3  000 word, 001 byte unsigned, 010 byte signed, 011 half unsigned, 100 half signed; stores treat 001/010 as byte and 011/100 as half.
REQ-007 cpu_addr  in  32  byte address.
REQ-008 cpu_wdata  in  32  store data, right-justified.
REQ-009 cpu_ready  out  1  high only in IDLE.
REQ-010 cpu_done  out  1  one-cycle completion pulse.
REQ-011 cpu_rdata  out  32  extended load result.
REQ-012 cpu_misalign  out  1  one-cycle alignment-fault pulse.
REQ-013 cpu_timeout  out  1  one-cycle timeout-fault pulse.
REQ-014 mem_req / mem_we  out  1 each; mem_adr  out  30  word address (cpu_addr[31:2]); mem_be  out  4; mem_wdata  out  32; mem_ack  in  1; mem_rdata  in  32.

Function
REQ-015 States SHALL be IDLE, REQ, DONE, FAULT; a request is accepted on a rising edge with cpu_valid=1 in IDLE.
REQ-016 On acceptance, op, we, addr, be and wdata SHALL be registered; mem_* outputs SHALL be driven from registers and stay stable throughout REQ.
REQ-017 Misaligned (half with addr[0]=1; word with addr[1:0]!=00) SHALL go to FAULT, with no mem_req, and pulse cpu_misalign and cpu_done in the FAULT cycle.
REQ-018 Aligned requests SHALL go to REQ with mem_req=1; mem_req SHALL stay high until the edge at which mem_ack=1 is sampled, then the block goes to DONE.
REQ-019 mem_ack sampled outside REQ SHALL be ignored.
REQ-020 DONE SHALL last one cycle with cpu_done=1, then return to IDLE; minimum accept-to-cpu_done latency is 2 cycles.
REQ-021 Byte enables: byte -> 0001/0010/0100/1000 for addr[1:0]=00/01/10/11; half -> 0011 (addr[1]=0) or 1100; word -> 1111; loads use the same mask.
REQ-022 Store data SHALL be lane-replicated: byte {4{wdata[7:0]}}, half {2{wdata[15:0]}}, word unchanged.
REQ-023 Loads SHALL capture mem_rdata at the ack edge, then select the addressed byte/half and zero- or sign-extend it per op; word passes unchanged.
REQ-024 cpu_rdata SHALL hold its value until the next load completes; stores and faults SHALL leave it unchanged.
REQ-025 An 8-bit cycle counter SHALL clear on entry to REQ; if it reaches TIMEOUT without ack, the block SHALL drop mem_req, go to FAULT and pulse cpu_timeout and cpu_done.
REQ-026 An ack arriving on the same edge as the timeout SHALL win: normal completion, no cpu_timeout.

Reset
REQ-027 rst SHALL force IDLE, mem_req=0, mem_we=0, mem_be=0000, mem_adr=0, mem_wdata=0, cpu_rdata=0, all pulses 0, and cpu_ready=1 on deassertion, including mid-REQ.

Structure
REQ-028 Package lsu_pkg SHALL hold the op encodings, the state enum and the byte-enable constants.
REQ-029 Load selection/extension SHALL be the combinational sub-module lsu_ld_ext.

Verification
REQ-030 lb at addr 0x103, ack after 3 cycles with mem_rdata=0x80FF_1234 -> mem_be=1000, mem_adr=0x40, cpu_rdata=0xFFFF_FF80, single cpu_done.
REQ-031 sh at 0x202, wdata=0x0000_BEEF, zero-wait ack -> mem_be=1100, mem_wdata=0xBEEF_BEEF, mem_we=1, cpu_done 2 cycles after accept.
REQ-032 lw at 0x101 -> no mem_req, cpu_misalign=1 and cpu_done=1 for one cycle, cpu_rdata unchanged.
REQ-033 TIMEOUT=4, no ack -> mem_req high for 4 cycles, then cpu_timeout pulse; ack landing on the 4th cycle -> normal done, no cpu_timeout.
REQ-034 rst asserted mid-REQ -> mem_req low immediately without a clock edge; after release, lhu at 0x2 with rdata 0x8001_0000 -> cpu_rdata=0x0000_8001.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: op encodings, FSM states,
// byte-enable constants and the small lane/alignment helpers.
package lsu_pkg;

  typedef enum logic [2:0] {
    OP_LW  = 3'b000,
    OP_LBU = 3'b001,
    OP_LB  = 3'b010,
    OP_LHU = 3'b011,
    OP_LH  = 3'b100
  } lsu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_DONE,
    ST_FAULT
  } lsu_state_e;

  typedef enum logic [1:0] {
    SZ_BYTE,
    SZ_HALF,
    SZ_WORD
  } lsu_size_e;

  localparam logic [3:0] BE_NONE = 4'b0000;
  localparam logic [3:0] BE_B0   = 4'b0001;
  localparam logic [3:0] BE_B1   = 4'b0010;
  localparam logic [3:0] BE_B2   = 4'b0100;
  localparam logic [3:0] BE_B3   = 4'b1000;
  localparam logic [3:0] BE_H0   = 4'b0011;
  localparam logic [3:0] BE_H1   = 4'b1100;
  localparam logic [3:0] BE_W    = 4'b1111;

  // Undefined op codes fall back to a full word access.
  function automatic lsu_size_e op_size(input logic [2:0] op);
    case (op)
      OP_LBU, OP_LB: return SZ_BYTE;
      OP_LHU, OP_LH: return SZ_HALF;
      default:       return SZ_WORD;
    endcase
  endfunction

  function automatic logic is_misaligned(input lsu_size_e size, input logic [1:0] off);
    case (size)
      SZ_HALF: return off[0];
      SZ_WORD: return off != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] byte_en(input lsu_size_e size, input logic [1:0] off);
    case (size)
      SZ_BYTE: begin
        case (off)
          2'd0:    return BE_B0;
          2'd1:    return BE_B1;
          2'd2:    return BE_B2;
          default: return BE_B3;
        endcase
      end
      SZ_HALF: return off[1] ? BE_H1 : BE_H0;
      default: return BE_W;
    endcase
  endfunction

  function automatic logic [31:0] lane_data(input lsu_size_e size, input logic [31:0] wdata);
    case (size)
      SZ_BYTE: return {4{wdata[7:0]}};
      SZ_HALF: return {2{wdata[15:0]}};
      default: return wdata;
    endcase
  endfunction

endpackage

// File: rtl/lsu_ctrl_if.sv
// CPU-side request/response and memory-side bus of the load/store unit.
// master = the controller, slave = the CPU/memory environment around it.
interface lsu_ctrl_if;
  logic        cpu_valid;
  logic        cpu_we;
  logic [2:0]  cpu_op;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_ready;
  logic        cpu_done;
  logic [31:0] cpu_rdata;
  logic        cpu_misalign;
  logic        cpu_timeout;
  logic        mem_req;
  logic        mem_we;
  logic [29:0] mem_adr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport master (
    input  cpu_valid, cpu_we, cpu_op, cpu_addr, cpu_wdata, mem_ack, mem_rdata,
    output cpu_ready, cpu_done, cpu_rdata, cpu_misalign, cpu_timeout,
           mem_req, mem_we, mem_adr, mem_be, mem_wdata
  );

  modport slave (
    output cpu_valid, cpu_we, cpu_op, cpu_addr, cpu_wdata, mem_ack, mem_rdata,
    input  cpu_ready, cpu_done, cpu_rdata, cpu_misalign, cpu_timeout,
           mem_req, mem_we, mem_adr, mem_be, mem_wdata
  );
endinterface

// File: rtl/lsu_ld_ext.sv
// Combinational load formatter: picks the addressed byte/half out of a
// memory word and zero- or sign-extends it according to the load op.
module lsu_ld_ext
  import lsu_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [1:0]  off,
  input  logic [31:0] raw,
  output logic [31:0] data
);

  logic [7:0]  lanes [4];
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign lanes[gi] = raw[8*gi +: 8];
  end

  assign byte_sel = lanes[off];
  assign half_sel = off[1] ? {lanes[3], lanes[2]} : {lanes[1], lanes[0]};

  always_comb begin
    data = raw;
    case (op)
      OP_LBU:  data = {24'd0, byte_sel};
      OP_LB:   data = {{24{byte_sel[7]}}, byte_sel};
      OP_LHU:  data = {16'd0, half_sel};
      OP_LH:   data = {{16{half_sel[15]}}, half_sel};
      default: data = raw;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Single-outstanding load/store controller: registers a CPU request, runs one
// memory handshake with an ack timeout, and reports done/misalign/timeout.
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst,
  lsu_ctrl_if.master bus
);

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  lsu_state_e  state_reg, state_next;
  logic [2:0]  op_reg;
  logic        we_reg;
  logic [31:0] addr_reg;
  logic [3:0]  be_reg;
  logic [31:0] wdata_reg;
  logic [7:0]  cnt_reg;
  logic        timeout_reg;
  logic [31:0] rdata_reg;
  logic [31:0] ld_data;
  lsu_size_e   req_size;
  logic        req_misalign;

  assign req_size     = op_size(bus.cpu_op);
  assign req_misalign = is_misaligned(req_size, bus.cpu_addr[1:0]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= ST_IDLE;
    else     state_reg <= state_next;
  end

  // An ack on the last permitted cycle takes priority over the timeout.
  always_comb begin
    state_next       = state_reg;
    bus.cpu_ready    = 1'b0;
    bus.cpu_done     = 1'b0;
    bus.cpu_misalign = 1'b0;
    bus.cpu_timeout  = 1'b0;
    bus.mem_req      = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        bus.cpu_ready = 1'b1;
        if (bus.cpu_valid) state_next = req_misalign ? ST_FAULT : ST_REQ;
      end
      ST_REQ: begin
        bus.mem_req = 1'b1;
        if (bus.mem_ack)              state_next = ST_DONE;
        else if (cnt_reg == CNT_LAST) state_next = ST_FAULT;
      end
      ST_DONE: begin
        bus.cpu_done = 1'b1;
        state_next   = ST_IDLE;
      end
      ST_FAULT: begin
        bus.cpu_done     = 1'b1;
        bus.cpu_misalign = ~timeout_reg;
        bus.cpu_timeout  = timeout_reg;
        state_next       = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_reg      <= OP_LW;
      we_reg      <= 1'b0;
      addr_reg    <= 32'd0;
      be_reg      <= BE_NONE;
      wdata_reg   <= 32'd0;
      cnt_reg     <= 8'd0;
      timeout_reg <= 1'b0;
      rdata_reg   <= 32'd0;
    end else begin
      if (state_reg == ST_IDLE && bus.cpu_valid) begin
        op_reg      <= bus.cpu_op;
        we_reg      <= bus.cpu_we;
        addr_reg    <= bus.cpu_addr;
        be_reg      <= byte_en(req_size, bus.cpu_addr[1:0]);
        wdata_reg   <= lane_data(req_size, bus.cpu_wdata);
        cnt_reg     <= 8'd0;
        timeout_reg <= 1'b0;
      end else if (state_reg == ST_REQ && !bus.mem_ack) begin
        if (cnt_reg == CNT_LAST) timeout_reg <= 1'b1;
        else                     cnt_reg     <= cnt_reg + 8'd1;
      end
      // Only completed loads update the result; stores and faults keep it.
      if (state_reg == ST_REQ && bus.mem_ack && !we_reg) rdata_reg <= ld_data;
    end
  end

  lsu_ld_ext u_ld_ext (
    .op   (op_reg),
    .off  (addr_reg[1:0]),
    .raw  (bus.mem_rdata),
    .data (ld_data)
  );

  assign bus.mem_we    = we_reg;
  assign bus.mem_adr   = addr_reg[31:2];
  assign bus.mem_be    = be_reg;
  assign bus.mem_wdata = wdata_reg;
  assign bus.cpu_rdata = rdata_reg;

endmodule
